// File: rtl/qea_pkg.sv
// qea_pkg: shared FSM encoding, default widths and amplitude-one constant for the QEA host loader
package qea_pkg;
  localparam int QEA_PE_NUM           = 4;
  localparam int QEA_DATA_WIDTH       = 32;
  localparam int QEA_STATE_ADDR_WIDTH = 16;
  localparam int QEA_CTX_ADDR_WIDTH   = 16;
  localparam int QEA_MAX_QBIT_WIDTH   = 6;
  localparam int QEA_NUM_FRAC_BIT     = 30;
  typedef enum logic [3:0] {
    IDLE, LOAD_CTX, INIT_STATE, START, RUN, RD_ISSUE, RD_WAIT, RD_OUT, DONE
  } state_e;
  // Fixed-point 1.0 with the given number of fraction bits
  function automatic logic [63:0] amp_one(input int frac);
    return 64'd1 << frac;
  endfunction
endpackage

// File: rtl/qea_row_counter.sv
// qea_row_counter: loadable up-counter with terminal-value flag
module qea_row_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] cnt,
  output logic         term
);
  logic [W-1:0] cnt_q, cnt_d;
  // load takes priority over increment
  always_comb cnt_d = load ? load_val : inc ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt  = cnt_q;
  assign term = cnt_q == term_val;
endmodule

// File: rtl/qea_host_loader.sv
// qea_host_loader: loads gate context and initial state into the QEA, runs it and streams the state back
module qea_host_loader import qea_pkg::*; #(
  parameter int PE_NUM                  = QEA_PE_NUM,
  parameter int DATA_WIDTH              = QEA_DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = QEA_STATE_ADDR_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = QEA_CTX_ADDR_WIDTH,
  parameter int MAX_QBIT_WIDTH          = QEA_MAX_QBIT_WIDTH,
  parameter int NUM_FRAC_BIT            = QEA_NUM_FRAC_BIT,
  localparam int STATE_DATA_WIDTH       = 2*DATA_WIDTH,
  localparam int LW                     = PE_NUM*STATE_DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_start,
  input  logic [MAX_QBIT_WIDTH-1:0]          cfg_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] cfg_ins_num,
  input  logic                               s_ctx_valid,
  output logic                               s_ctx_ready,
  input  logic [2*DATA_WIDTH-1:0]            s_ctx_data,
  output logic                               q_ctx_en,
  output logic                               q_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] q_ctx_addr,
  output logic [2*DATA_WIDTH-1:0]            q_ctx_data,
  output logic                               q_state_ena,
  output logic                               q_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        q_state_addra,
  output logic [LW-1:0]                      q_state_dina,
  output logic                               q_start,
  input  logic                               q_complete,
  input  logic [LW-1:0]                      q_state_dout,
  output logic                               m_state_valid,
  input  logic                               m_state_ready,
  output logic [LW-1:0]                      m_state_data,
  output logic                               m_state_last,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [31:0]                        exec_cycles
);
  localparam logic [63:0] ONE_RE = amp_one(NUM_FRAC_BIT);
  localparam logic [LW-1:0] INIT_ROW = {ONE_RE[DATA_WIDTH-1:0], {(LW-DATA_WIDTH){1'b0}}};
  state_e state_q, state_d;
  logic [MAX_QBIT_WIDTH-1:0] qbit_q, qbit_d;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q, ins_d, ctx_addr_q, ctx_addr_d, ctx_cnt;
  logic err_q, err_d, ctx_we_q, ctx_we_d;
  logic [31:0] exec_q, exec_d;
  logic [2*DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
  logic [LW-1:0] rd_data_q, rd_data_d;
  logic [STATE_ADDR_WIDTH-1:0] row_cnt, row_last;
  logic ctx_load, ctx_inc, ctx_term, row_load, row_inc, row_term, cfg_ok;
  assign cfg_ok   = int'(cfg_qbit_num) >= 2 && int'(cfg_qbit_num) <= STATE_ADDR_WIDTH + 2;
  assign row_last = ~({STATE_ADDR_WIDTH{1'b1}} << (qbit_q - MAX_QBIT_WIDTH'(2)));
  qea_row_counter #(.W(GATE_CONTEXT_ADDR_WIDTH)) u_ctx_cnt (
    .clk(clk), .rst(rst), .load(ctx_load), .load_val('0), .inc(ctx_inc),
    .term_val(ins_q - GATE_CONTEXT_ADDR_WIDTH'(1)), .cnt(ctx_cnt), .term(ctx_term)
  );
  qea_row_counter #(.W(STATE_ADDR_WIDTH)) u_row_cnt (
    .clk(clk), .rst(rst), .load(row_load), .load_val('0), .inc(row_inc),
    .term_val(row_last), .cnt(row_cnt), .term(row_term)
  );
  // next-state, datapath updates and per-state strobes
  always_comb begin
    state_d       = state_q;
    qbit_d        = qbit_q;
    ins_d         = ins_q;
    err_d         = err_q;
    exec_d        = exec_q;
    ctx_we_d      = 1'b0;
    ctx_addr_d    = ctx_addr_q;
    ctx_data_d    = ctx_data_q;
    rd_data_d     = rd_data_q;
    ctx_load      = 1'b0;
    ctx_inc       = 1'b0;
    row_load      = 1'b0;
    row_inc       = 1'b0;
    s_ctx_ready   = 1'b0;
    q_state_ena   = 1'b0;
    q_state_wea   = 1'b0;
    q_state_addra = '0;
    q_state_dina  = '0;
    q_start       = 1'b0;
    m_state_valid = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: if (cfg_start) begin
        err_d = !cfg_ok;
        if (cfg_ok) begin
          qbit_d   = cfg_qbit_num;
          ins_d    = cfg_ins_num;
          ctx_load = 1'b1;
          row_load = 1'b1;
          state_d  = cfg_ins_num == '0 ? INIT_STATE : LOAD_CTX;
        end
      end
      LOAD_CTX: begin
        s_ctx_ready = 1'b1;
        if (s_ctx_valid) begin
          ctx_we_d   = 1'b1;
          ctx_addr_d = ctx_cnt;
          ctx_data_d = s_ctx_data;
          ctx_inc    = 1'b1;
          state_d    = ctx_term ? INIT_STATE : LOAD_CTX;
        end
      end
      INIT_STATE: begin
        q_state_ena   = 1'b1;
        q_state_wea   = 1'b1;
        q_state_addra = row_cnt;
        q_state_dina  = row_cnt == '0 ? INIT_ROW : '0;
        row_inc       = !row_term;
        row_load      = row_term;
        state_d       = row_term ? START : INIT_STATE;
      end
      START: begin
        q_start = 1'b1;
        exec_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        exec_d  = exec_q + {31'd0, exec_q != '1};
        state_d = q_complete ? RD_ISSUE : RUN;
      end
      RD_ISSUE: begin
        q_state_ena   = 1'b1;
        q_state_addra = row_cnt;
        state_d       = RD_WAIT;
      end
      RD_WAIT: begin
        rd_data_d = q_state_dout;
        state_d   = RD_OUT;
      end
      RD_OUT: begin
        m_state_valid = 1'b1;
        if (m_state_ready) begin
          row_inc = !row_term;
          state_d = row_term ? DONE : RD_ISSUE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      qbit_q     <= '0;
      ins_q      <= '0;
      err_q      <= 1'b0;
      exec_q     <= '0;
      ctx_we_q   <= 1'b0;
      ctx_addr_q <= '0;
      ctx_data_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      qbit_q     <= qbit_d;
      ins_q      <= ins_d;
      err_q      <= err_d;
      exec_q     <= exec_d;
      ctx_we_q   <= ctx_we_d;
      ctx_addr_q <= ctx_addr_d;
      ctx_data_q <= ctx_data_d;
      rd_data_q  <= rd_data_d;
    end
  end
  assign q_ctx_en     = ctx_we_q;
  assign q_ctx_wea    = ctx_we_q;
  assign q_ctx_addr   = ctx_addr_q;
  assign q_ctx_data   = ctx_data_q;
  assign m_state_data = rd_data_q;
  assign m_state_last = state_q == RD_OUT && row_term;
  assign busy         = state_q != IDLE;
  assign err          = err_q;
  assign exec_cycles  = exec_q;
endmodule

// File: tb/tb_qea_host_loader.sv
// tb_qea_host_loader: scoreboard bench for the QEA host loader with a stub QEA and state RAM
module tb_qea_host_loader;
  logic clk = 0, rst = 1, cfg_start = 0, s_ctx_valid = 0, m_state_ready = 1, q_complete = 0;
  logic [5:0] cfg_qbit_num = 0;
  logic [15:0] cfg_ins_num = 0;
  logic [63:0] s_ctx_data = 0;
  logic s_ctx_ready, q_ctx_en, q_ctx_wea, q_state_ena, q_state_wea, q_start;
  logic m_state_valid, m_state_last, busy, done, err;
  logic [15:0] q_ctx_addr, q_state_addra;
  logic [63:0] q_ctx_data;
  logic [255:0] q_state_dina, q_state_dout = 0, m_state_data;
  logic [31:0] exec_cycles;
  qea_host_loader dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_qbit_num(cfg_qbit_num), .cfg_ins_num(cfg_ins_num),
    .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready), .s_ctx_data(s_ctx_data),
    .q_ctx_en(q_ctx_en), .q_ctx_wea(q_ctx_wea), .q_ctx_addr(q_ctx_addr), .q_ctx_data(q_ctx_data),
    .q_state_ena(q_state_ena), .q_state_wea(q_state_wea), .q_state_addra(q_state_addra),
    .q_state_dina(q_state_dina), .q_start(q_start), .q_complete(q_complete), .q_state_dout(q_state_dout),
    .m_state_valid(m_state_valid), .m_state_ready(m_state_ready), .m_state_data(m_state_data),
    .m_state_last(m_state_last), .busy(busy), .done(done), .err(err), .exec_cycles(exec_cycles)
  );
  always #5 clk = ~clk;
  localparam logic [255:0] ROW0 = {32'h4000_0000, 224'd0};
  typedef struct packed {logic [15:0] a; logic [63:0] d;} cw_t;
  typedef struct packed {logic [15:0] a; logic [255:0] d;} sw_t;
  typedef struct packed {logic [255:0] d; logic l;} rb_t;
  cw_t ctx_q[$];
  sw_t st_q[$];
  rb_t rb_q[$];
  cw_t ce;
  sw_t se;
  rb_t re;
  int passed = 0, total = 0, rb_hs = 0, act = 0;
  logic hold_v = 0;
  logic [255:0] hold_d = 0;
  logic fill_req = 0;
  logic [255:0] mem [0:15];
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask
  function automatic logic [63:0] cdat(input int i);
    return {32'(32'hC0DE_0000 + i), ~32'(i)};
  endfunction
  function automatic logic [255:0] pat(input int r);
    logic [255:0] p;
    for (int k = 0; k < 4; k++) p[k*64 +: 64] = {32'(32'h1111_0000 + r*16 + k), 32'(32'h2222_0000 + r)};
    return p;
  endfunction
  function automatic logic outs_nz();
    return |{s_ctx_ready, q_ctx_en, q_ctx_wea, q_ctx_addr, q_ctx_data, q_state_ena, q_state_wea,
             q_state_addra, q_state_dina, q_start, m_state_valid, m_state_data, m_state_last,
             busy, done, err, exec_cycles};
  endfunction
  // state RAM with one-cycle read latency; fill_req models the QEA overwriting the state
  always @(posedge clk) begin
    if (fill_req) for (int r = 0; r < 16; r++) mem[r] <= pat(r);
    else if (q_state_ena && q_state_wea) mem[q_state_addra[3:0]] <= q_state_dina;
    if (q_state_ena && !q_state_wea) q_state_dout <= mem[q_state_addra[3:0]];
  end
  // monitor: pops the scoreboard whenever the DUT presents a write or a result beat
  always @(negedge clk) begin
    if (q_ctx_en || q_ctx_wea || q_state_ena || q_state_wea || q_start) act++;
    if (q_ctx_en && q_ctx_wea) begin
      if (ctx_q.size() == 0) chk("ctx_unexpected", {q_ctx_addr, q_ctx_data}, 0);
      else begin
        ce = ctx_q.pop_front();
        chk("ctx_addr", q_ctx_addr, ce.a);
        chk("ctx_data", q_ctx_data, ce.d);
      end
    end
    if (q_state_ena && q_state_wea) begin
      if (st_q.size() == 0) chk("state_unexpected", q_state_addra, 16'hffff);
      else begin
        se = st_q.pop_front();
        chk("state_addr", q_state_addra, se.a);
        chk("state_data", q_state_dina, se.d);
      end
    end
    if (hold_v) begin
      chk("hold_valid", m_state_valid, 1);
      chk("hold_data", m_state_data, hold_d);
    end
    hold_v = m_state_valid && !m_state_ready;
    hold_d = m_state_data;
    if (m_state_valid && m_state_ready) begin
      rb_hs++;
      if (rb_q.size() == 0) chk("rb_unexpected", m_state_data, 0);
      else begin
        re = rb_q.pop_front();
        chk("rb_data", m_state_data, re.d);
        chk("rb_last", m_state_last, re.l);
      end
    end
  end
  task automatic push_ctx(input int n);
    for (int i = 0; i < n; i++) ctx_q.push_back({16'(i), cdat(i)});
  endtask
  task automatic push_wr(input int rows);
    for (int r = 0; r < rows; r++) st_q.push_back({16'(r), r == 0 ? ROW0 : 256'd0});
  endtask
  task automatic push_rb(input int rows);
    for (int r = 0; r < rows; r++) rb_q.push_back({pat(r), r == rows - 1});
  endtask
  task automatic start(input int qb, input int ins);
    cfg_qbit_num = 6'(qb);
    cfg_ins_num = 16'(ins);
    cfg_start = 1;
    @(posedge clk); #1;
    cfg_start = 0;
  endtask
  task automatic feed(input int n, input bit tog);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      s_ctx_valid = 1;
      s_ctx_data = cdat(i);
      while (!s_ctx_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) begin chk("ctx_ready_timeout", 0, 1); s_ctx_valid = 0; return; end
      @(posedge clk); #1;
      if (tog) begin s_ctx_valid = 0; @(posedge clk); #1; end
    end
    s_ctx_valid = 0;
  endtask
  task automatic wait_qstart(output bit ok);
    int t = 0;
    while (!q_start && t < 500) begin @(posedge clk); #1; t++; end
    ok = q_start;
    if (!ok) chk("qstart_timeout", 0, 1);
  endtask
  task automatic finish_job(input int rows, input int stall_row);
    int base = rb_hs, t = 0, stall = 0;
    bit ok;
    wait_qstart(ok);
    if (!ok) return;
    repeat (500) @(posedge clk);
    #1;
    q_complete = 1;
    fill_req = 1;
    @(posedge clk); #1;
    q_complete = 0;
    fill_req = 0;
    while (rb_hs < base + rows && t < 300) begin
      @(posedge clk); #1; t++;
      m_state_ready = !(m_state_valid && rb_hs - base == stall_row && stall < 10);
      if (!m_state_ready) stall++;
    end
    m_state_ready = 1;
    chk("readback_count", 32'(rb_hs - base), 32'(rows));
    chk("done_pulse", done, 1);
    chk("exec_cycles", exec_cycles, 500);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("ctx_q_empty", ctx_q.size(), 0);
    chk("st_q_empty", st_q.size(), 0);
    chk("rb_q_empty", rb_q.size(), 0);
  endtask
  initial begin
    int a0;
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_nz(), 0);
    rst = 0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    // qbit 4, 89 words back to back, result stall on row 1
    push_ctx(89); push_wr(4); push_rb(4);
    start(4, 89);
    chk("busy_load", busy, 1);
    feed(89, 0);
    finish_job(4, 1);
    // qbit 3, valid toggling every other cycle
    push_ctx(10); push_wr(2); push_rb(2);
    start(3, 10);
    feed(10, 1);
    finish_job(2, -1);
    // out-of-range qubit counts below and above the legal window
    a0 = act;
    start(1, 5);
    chk("err_low_qbit", err, 1);
    chk("busy_low_qbit", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("no_activity_low", 32'(act - a0), 0);
    chk("err_sticky", err, 1);
    start(19, 5);
    chk("err_high_qbit", err, 1);
    chk("busy_high_qbit", busy, 0);
    // smallest legal job: one row, no context words
    push_wr(1); push_rb(1);
    start(2, 0);
    chk("err_cleared", err, 0);
    chk("busy_min", busy, 1);
    finish_job(1, -1);
    // reset after 40 context words, then a fresh job
    push_ctx(40);
    start(4, 89);
    feed(40, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_load_outputs", outs_nz(), 0);
    chk("rst_load_ctx_q", ctx_q.size(), 0);
    push_ctx(6); push_wr(2); push_rb(2);
    start(3, 6);
    feed(6, 0);
    finish_job(2, -1);
    // reset while running; a late completion must be ignored
    push_wr(1);
    start(2, 0);
    wait_qstart(ok);
    repeat (20) @(posedge clk);
    #1;
    chk("run_busy", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_run_outputs", outs_nz(), 0);
    a0 = act;
    q_complete = 1;
    @(posedge clk); #1;
    q_complete = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("late_complete_busy", busy, 0);
    chk("late_complete_activity", 32'(act - a0), 0);
    chk("late_complete_valid", m_state_valid, 0);
    chk("st_q_empty_run", st_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/qea_host_loader.md
QEA_HOST_LOADER -- requirements
Module: qea_host_loader

Interface
REQ-001 Parameter PE_NUM, default 4, number of processing elements (state-word lanes).
REQ-002 Parameter DATA_WIDTH, default 32, fixed-point component width; STATE_DATA_WIDTH = 2*DATA_WIDTH.
REQ-003 Parameter STATE_ADDR_WIDTH, default 16, QEA state RAM address width.
REQ-004 Parameter GATE_CONTEXT_ADDR_WIDTH, default 16, QEA context RAM address width.
REQ-005 Parameter MAX_QBIT_WIDTH, default 6, width of the qubit-count field.
REQ-006 Parameter NUM_FRAC_BIT, default 30, fraction bits of amplitude format.
REQ-007 Clocking SHALL be one clock; reset is synchronous and active-high: clk in 1 (all logic on rising edge); rst in 1 (synchronous, active-high).
REQ-008 cfg_start in 1 job start pulse; cfg_qbit_num in MAX_QBIT_WIDTH; cfg_ins_num in GATE_CONTEXT_ADDR_WIDTH, context word count.
REQ-009 s_ctx_valid in 1, s_ctx_ready out 1, s_ctx_data in 2*DATA_WIDTH: context word stream.
REQ-010 q_ctx_en, q_ctx_wea out 1; q_ctx_addr out GATE_CONTEXT_ADDR_WIDTH; q_ctx_data out 2*DATA_WIDTH.
REQ-011 q_state_ena, q_state_wea out 1; q_state_addra out STATE_ADDR_WIDTH; q_state_dina out PE_NUM*STATE_DATA_WIDTH.
REQ-012 q_start out 1; q_complete in 1; q_state_dout in PE_NUM*STATE_DATA_WIDTH.
REQ-013 m_state_valid out 1, m_state_ready in 1, m_state_data out PE_NUM*STATE_DATA_WIDTH, m_state_last out 1: result stream.
REQ-014 busy out 1; done out 1 (one-cycle pulse); err out 1 (sticky until next cfg_start); exec_cycles out 32.

Function
REQ-015 FSM states SHALL be IDLE, LOAD_CTX, INIT_STATE, START, RUN, RD_ISSUE, RD_WAIT, RD_OUT, DONE.
REQ-016 IDLE: cfg_start with 2 <= cfg_qbit_num <= STATE_ADDR_WIDTH+2 latches config and goes to LOAD_CTX (INIT_STATE if cfg_ins_num==0); invalid qbit_num sets err, stays IDLE.
REQ-017 LOAD_CTX: s_ctx_ready=1; each accepted word writes q_ctx_en=q_ctx_wea=1 at addresses 0,1,... in the following cycle; exit to INIT_STATE after cfg_ins_num words.
REQ-018 INIT_STATE: writes ROWS = 2^(qbit_num-2) consecutive addresses, one per cycle, q_state_ena=q_state_wea=1.
REQ-019 Address 0 data: PE0 lane (most significant STATE_DATA_WIDTH bits) real part = 1<<NUM_FRAC_BIT (0x40000000 at defaults), all other bits 0; other rows all-zero.
REQ-020 START: q_start=1 for exactly one cycle; exec_cycles cleared to 0 that cycle.
REQ-021 RUN: exec_cycles increments each cycle (saturating at all-ones) until q_complete==1, then go to RD_ISSUE.
REQ-022 Readback: RD_ISSUE drives q_state_ena=1, q_state_wea=0, row address; RD_WAIT one cycle (read latency 1); RD_OUT captures q_state_dout into m_state_data and holds m_state_valid until m_state_ready.
REQ-023 m_state_last=1 with row ROWS-1; data and valid SHALL be stable while valid&&!ready.
REQ-024 After last handshake go to DONE: done pulses one cycle, return to IDLE.
REQ-025 cfg_start outside IDLE SHALL be ignored; busy=1 in every state except IDLE.
REQ-026 All q_* enables and q_start SHALL be 0 in states that do not drive them.

Reset
REQ-027 rst SHALL force IDLE, all outputs 0 (s_ctx_ready, q_*, m_state_*, busy, done, err, exec_cycles), and all counters 0 on the next edge, including mid-job.
REQ-028 rst asserted during RUN SHALL abandon the job; a later q_complete SHALL be ignored in IDLE.

Structure
REQ-029 A shared package qea_pkg SHALL hold the FSM state enum, default widths, and the amplitude-one constant.
REQ-030 One sub-module, qea_row_counter (load/increment/terminal flag), SHALL serve as row and context-word counter.

Verification
REQ-031 qbit_num=4, ins_num=89, continuous valid -> 89 ctx writes at addr 0..88, then 4 state writes with addr0 = 0x40000000_00000000 in PE0 lane.
REQ-032 s_ctx_valid toggling every other cycle -> exactly ins_num writes, no address gaps or repeats.
REQ-033 Stub QEA asserts q_complete 500 cycles after q_start -> exec_cycles=500, readback of 4 rows, last on row 3.
REQ-034 m_state_ready held low 10 cycles on row 1 -> data stable, no row skipped.
REQ-035 cfg_qbit_num=1 -> err=1, busy=0, no q_* activity.
REQ-036 rst during LOAD_CTX at word 40 -> all outputs 0 next cycle; new job completes normally.
